// File: rtl/icache_pkg.sv
// Shared icache definitions: geometry defaults, bus word types and refill FSM encodings.
package icache_pkg;
    localparam int ICACHE_IDX_WIDTH = 6;
    localparam int ICACHE_OFF_WIDTH = 2;

    typedef logic [31:0] addr_tp;
    typedef logic [31:0] word_tp;

    localparam logic [0:0] ICACHE_IDLE   = 1'b0;
    localparam logic [0:0] ICACHE_REFILL = 1'b1;
endpackage

// File: rtl/icache_if.sv
// Fetcher and memory-controller signals of the icache; master drives requests and refill data.
interface icache_if;
    import icache_pkg::*;

    logic   if_rd_en;
    addr_tp if_rd_addr;
    logic   if_hit;
    word_tp if_hit_inst;
    logic   mem_req;
    addr_tp mem_addr;
    logic   mem_vld;
    word_tp mem_data;

    modport master (
        output if_rd_en, if_rd_addr, mem_vld, mem_data,
        input  if_hit, if_hit_inst, mem_req, mem_addr
    );

    modport slave (
        input  if_rd_en, if_rd_addr, mem_vld, mem_data,
        output if_hit, if_hit_inst, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_refill.sv
// Refill FSM: walks one line word by word on the memory port and tells the arrays when to write.
module icache_refill
    import icache_pkg::*;
#(
    parameter int OFF_WIDTH = ICACHE_OFF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 miss,
    input  addr_tp               line_base,
    input  logic                 mem_vld,
    output logic                 mem_req,
    output addr_tp               mem_addr,
    output logic                 start,
    output logic                 fill_we,
    output logic [OFF_WIDTH-1:0] fill_cnt,
    output logic                 fill_last
);
    localparam logic [OFF_WIDTH-1:0] LAST = '1;

    logic [0:0]           state;
    logic [OFF_WIDTH-1:0] cnt;

    // Misses seen during a refill are dropped; the fetcher simply retries later.
    assign start     = rdy && (state == ICACHE_IDLE) && miss;
    assign fill_we   = rdy && (state == ICACHE_REFILL) && mem_vld;
    assign fill_cnt  = cnt;
    assign fill_last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ICACHE_IDLE;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (start) begin
            state    <= ICACHE_REFILL;
            cnt      <= '0;
            mem_req  <= 1'b1;
            mem_addr <= line_base;
        end else if (fill_we) begin
            cnt <= cnt + OFF_WIDTH'(1);
            if (fill_last) begin
                state   <= ICACHE_IDLE;
                mem_req <= 1'b0;
            end else begin
                // Only the word field moves, so the request stays inside the line.
                mem_addr <= {mem_addr[31:OFF_WIDTH+2], cnt + OFF_WIDTH'(1), 2'b00};
            end
        end
    end
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with same-cycle hit and a word-serial line refill.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_WIDTH = ICACHE_IDX_WIDTH,
    parameter int OFF_WIDTH = ICACHE_OFF_WIDTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    icache_if.slave bus
);
    localparam int TAG_WIDTH = 32 - IDX_WIDTH - OFF_WIDTH - 2;
    localparam int LINES     = 1 << IDX_WIDTH;
    localparam int WORDS     = 1 << OFF_WIDTH;

    logic [TAG_WIDTH-1:0] tag, rtag;
    logic [IDX_WIDTH-1:0] idx, ridx;
    logic [OFF_WIDTH-1:0] off, fill_cnt;
    logic [TAG_WIDTH-1:0] tag_arr [LINES];
    word_tp               data_arr [LINES][WORDS];
    logic [LINES-1:0]     valid;
    logic                 hit, miss, start, fill_we, fill_last;
    addr_tp               line_base, mem_addr;
    logic                 unused_ok;

    assign off       = bus.if_rd_addr[OFF_WIDTH+1:2];
    assign idx       = bus.if_rd_addr[IDX_WIDTH+OFF_WIDTH+1:OFF_WIDTH+2];
    assign tag       = bus.if_rd_addr[31:32-TAG_WIDTH];
    assign line_base = {tag, idx, {(OFF_WIDTH+2){1'b0}}};

    // The refill address register already carries the line being filled.
    assign ridx = mem_addr[IDX_WIDTH+OFF_WIDTH+1:OFF_WIDTH+2];
    assign rtag = mem_addr[31:32-TAG_WIDTH];

    assign hit              = bus.if_rd_en && valid[idx] && (tag_arr[idx] == tag);
    assign miss             = bus.if_rd_en && !hit;
    assign bus.if_hit       = hit;
    assign bus.if_hit_inst  = data_arr[idx][off];
    assign bus.mem_addr     = mem_addr;
    assign unused_ok        = ^{bus.if_rd_addr[1:0], mem_addr[OFF_WIDTH+1:0]};

    icache_refill #(
        .OFF_WIDTH(OFF_WIDTH)
    ) u_refill (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .miss      (miss),
        .line_base (line_base),
        .mem_vld   (bus.mem_vld),
        .mem_req   (bus.mem_req),
        .mem_addr  (mem_addr),
        .start     (start),
        .fill_we   (fill_we),
        .fill_cnt  (fill_cnt),
        .fill_last (fill_last)
    );

    // A line is invalid from refill start until its last word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (start) begin
            valid[idx] <= 1'b0;
        end else if (fill_we && fill_last) begin
            valid[ridx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_arr[ridx][fill_cnt] <= bus.mem_data;
            if (fill_last) begin
                tag_arr[ridx] <= rtag;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected refill addresses are queued at each miss and popped per served word.
module tb_icache;
    import icache_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    int   n_chk;
    int   n_pass;
    addr_tp exp_addr [$];

    icache_if bus ();

    icache dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory contents: 0xA0..0xA3 for line 0x10, distinct per line elsewhere.
    function automatic word_tp mem_word(input addr_tp a);
        word_tp hi;
        hi = {4'd0, a[31:4]} - 32'd1;
        return 32'hA0 + {30'd0, a[3:2]} + (hi << 8);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input addr_tp a, input bit h, input word_tp w);
        bus.if_rd_en   = 1'b1;
        bus.if_rd_addr = a;
        @(negedge clk);
        chk("hit", 32'(bus.if_hit), 32'(h));
        if (h) chk("inst", bus.if_hit_inst, w);
        cyc();
    endtask

    task automatic start_miss(input addr_tp a);
        bus.if_rd_en   = 1'b1;
        bus.if_rd_addr = a;
        @(negedge clk);
        chk("miss", 32'(bus.if_hit), 32'd0);
        for (int k = 0; k < 4; k++) exp_addr.push_back({a[31:4], 4'h0} + 32'(4 * k));
        cyc();
    endtask

    task automatic serve_one(input int lat, input addr_tp fa, input bit fh, input word_tp fi);
        addr_tp ea;
        bus.if_rd_en   = 1'b1;
        bus.if_rd_addr = fa;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("req_hold", 32'(bus.mem_req), 32'd1);
            cyc();
        end
        ea = (exp_addr.size() > 0) ? exp_addr[0] : 32'hFFFF_FFFF;
        bus.mem_vld  = 1'b1;
        bus.mem_data = mem_word(ea);
        @(negedge clk);
        chk("mem_req", 32'(bus.mem_req), 32'd1);
        if (exp_addr.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
        chk("fill_hit", 32'(bus.if_hit), 32'(fh));
        if (fh) chk("fill_inst", bus.if_hit_inst, fi);
        cyc();
        bus.mem_vld = 1'b0;
    endtask

    task automatic refill(input addr_tp a, input int lat);
        start_miss(a);
        repeat (4) serve_one(lat, a, 1'b0, 32'd0);
        bus.if_rd_en   = 1'b1;
        bus.if_rd_addr = a;
        @(negedge clk);
        chk("done_req", 32'(bus.mem_req), 32'd0);
        fetch(a, 1'b1, mem_word(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        rdy = 1'b1;
        bus.if_rd_en = 1'b0;
        bus.if_rd_addr = '0;
        bus.mem_vld = 1'b0;
        bus.mem_data = '0;

        // Reset state
        cyc();
        cyc();
        bus.if_rd_en = 1'b1;
        bus.if_rd_addr = 32'h10;
        @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_hit", 32'(bus.if_hit), 32'd0);
        cyc();
        rst = 1'b0;

        // Cold miss, then same-line hits with ignored low address bits
        refill(32'h10, 1);
        fetch(32'h14, 1'b1, 32'hA1);
        fetch(32'h1B, 1'b1, 32'hA2);
        fetch(32'h1C, 1'b1, 32'hA3);

        // Stray mem_vld while idle must not disturb the line
        bus.mem_vld = 1'b1;
        bus.mem_data = 32'hDEAD_BEEF;
        fetch(32'h14, 1'b1, 32'hA1);
        bus.mem_vld = 1'b0;
        @(negedge clk);
        chk("idle_req", 32'(bus.mem_req), 32'd0);
        fetch(32'h14, 1'b1, 32'hA1);

        // Conflict eviction on idx 1
        refill(32'h410, 2);
        refill(32'h10, 1);

        // Hit-under-miss
        refill(32'h20, 1);
        start_miss(32'h1000);
        serve_one(1, 32'h24, 1'b1, mem_word(32'h24));
        serve_one(2, 32'h2000, 1'b0, 32'd0);
        serve_one(1, 32'h1004, 1'b0, 32'd0);
        serve_one(1, 32'h28, 1'b1, mem_word(32'h28));
        bus.if_rd_addr = 32'h1000;
        @(negedge clk);
        chk("hum_req", 32'(bus.mem_req), 32'd0);
        fetch(32'h1008, 1'b1, mem_word(32'h1008));

        // Reset mid-refill
        start_miss(32'h30);
        serve_one(1, 32'h30, 1'b0, 32'd0);
        serve_one(1, 32'h30, 1'b0, 32'd0);
        rst = 1'b1;
        cyc();
        bus.if_rd_addr = 32'h20;
        @(negedge clk);
        chk("rrst_req", 32'(bus.mem_req), 32'd0);
        chk("rrst_hit", 32'(bus.if_hit), 32'd0);
        cyc();
        rst = 1'b0;
        exp_addr.delete();
        refill(32'h38, 1);

        // rdy stall with ignored mem_vld pulses
        start_miss(32'h40);
        serve_one(1, 32'h40, 1'b0, 32'd0);
        serve_one(1, 32'h40, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            bus.mem_vld = 1'b1;
            bus.mem_data = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("stall_req", 32'(bus.mem_req), 32'd1);
            chk("stall_addr", bus.mem_addr, 32'h48);
            cyc();
        end
        rdy = 1'b1;
        bus.mem_vld = 1'b0;
        serve_one(1, 32'h40, 1'b0, 32'd0);
        serve_one(1, 32'h40, 1'b0, 32'd0);
        fetch(32'h48, 1'b1, mem_word(32'h48));
        fetch(32'h4C, 1'b1, mem_word(32'h4C));
        fetch(32'h40, 1'b1, mem_word(32'h40));
        chk("sb_drain", 32'(exp_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
